// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, IF/ID pipeline latch and BOOT/RUN/HALT fetch control
// with stall, flush, branch/jump redirect and a saturating delivered-instruction counter.
module instruction_fetch_unit #(
    parameter int          MEM_WORDS = 30,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    output logic [31:0] ReadAddress,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic [15:0] FetchCount
);
    localparam logic [31:0] LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, pcp4_q;
    logic        valid_q;
    logic [15:0] cnt_q;
    logic        squash, capture;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] target;
    logic        unused_ok;

    assign pc_plus4  = pc_q + 32'd4;
    assign redirect  = Branch | Jump;
    assign target    = Branch ? {BranchTarget[31:2], 2'b00} : {pc_plus4[31:28], JumpIndex, 2'b00};
    assign unused_ok = &{1'b0, BranchTarget[1:0]};

    // Flush squashes IF/ID independently of whatever the PC does this edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        squash  = Flush;
        capture = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: if (!Stall) begin
                if (redirect) begin
                    pc_d   = target;
                    squash = 1'b1;
                end else if (pc_q >= LIMIT) begin
                    squash  = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_d    = pc_plus4;
                    capture = 1'b1;
                end
            end
            HALT: begin
                squash = 1'b1;
                if (!Stall && redirect) begin
                    pc_d    = target;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (squash) begin
                instr_q <= '0;
                pcp4_q  <= '0;
                valid_q <= 1'b0;
            end else if (capture) begin
                instr_q <= Instruction;
                pcp4_q  <= pc_plus4;
                valid_q <= 1'b1;
                cnt_q   <= (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            end
        end
    end

    assign ReadAddress       = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pcp4_q;
    assign IF_ID_Valid       = valid_q;
    assign Halted            = (state_q == HALT);
    assign FetchCount        = cnt_q;
endmodule
